operand_latch_bank: RTL and testbench
=====================================

// Module: operand_latch_bank
// PURPOSE
//  N-channel, W-bit operand register bank fed by active-low pushbuttons; next
//  generation of the 2x4 operand latch in the sum/UART datapath.
//  Each save button is synchronised, debounced and edge-detected, so one press
//  makes exactly one write. Per-channel loaded flags and a write strobe tell the
//  downstream adder and UART framer when operands are fresh.
// PARAMETERS
//  DATA_W          4   width of data_input and of each channel register
//  CHANNELS        2   number of operand registers (>=1)
//  DEBOUNCE_CYCLES 16  consecutive stable synced samples needed to accept a level change (>=1)
// PORTS
//  clk          in   1                 system clock, all logic on posedge
//  reset        in   1                 synchronous, active-high reset
//  data_input   in   DATA_W            operand value (switches), sampled on commit
//  save_n       in   CHANNELS          per-channel save pushbuttons, active low, async
//  save_seq_n   in   1                 sequential save button, active low (SEQ_LOAD_EN only)
//  q            out  CHANNELS*DATA_W   channel registers; channel k at [k*DATA_W +: DATA_W]
//  loaded       out  CHANNELS          bit k set once channel k has been written since reset
//  all_loaded   out  1                 &loaded
//  wr_pulse     out  1                 1-cycle strobe, high on the cycle after any channel write
//  wr_ch        out  max(1,$clog2(CHANNELS))  index of the last channel written
//  seq_ptr      out  max(1,$clog2(CHANNELS))  next channel for sequential save (SEQ_LOAD_EN only)
// BEHAVIOUR
//  - Clock and reset: single clock. Reset is synchronous and active-high.
//  - Reset values (registered outputs): q=0, loaded=0, wr_pulse=0, wr_ch=0, seq_ptr=0.
//    all_loaded is combinational from loaded, so it reads 0 in the cycle after reset.
//    Internally, sync FFs=1, debounced state=1 (released) and debounce counters=0.
//    Reset asserted mid-debounce discards the partial count.
//  - Synchroniser: 2-FF synchroniser per button input.
//  - Debounce: per button, 1 state bit plus a counter of width $clog2(DEBOUNCE_CYCLES+1).
//    * If the synced value equals the state, the counter clears.
//    * Otherwise the counter increments.
//    * On the DEBOUNCE_CYCLES-th consecutive differing sample, the state takes the synced
//      value and the counter clears.
//    * Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
//  - Commit: a debounced 1->0 transition of a button (press) commits. A 0->1 transition
//    (release) does nothing.
//    * On a commit for channel k, the same edge loads q[k] <= data_input (value sampled at
//      that edge) and sets loaded[k].
//    * The next cycle shows wr_pulse=1 and wr_ch=k.
//    * Latency: with save_n[k] low and stable from edge 0, q[k] updates at edge
//      DEBOUNCE_CYCLES+2.
//  - A button held through reset release commits once after DEBOUNCE_CYCLES+2 cycles.
//    This is intended.
//  - Simultaneous commits: every committing channel is written in the same cycle with the
//    same data_input. wr_pulse is a single 1-cycle pulse. wr_ch reports the highest
//    committing index.
//  - Holding a button produces no repeat. Another commit needs a debounced release and then
//    a new press.
//  - Back-to-back commits on different channels in consecutive cycles: wr_pulse stays high
//    for both cycles, and wr_ch follows each commit.
//  - loaded bits are sticky until reset. Rewriting a loaded channel overwrites q and keeps
//    loaded=1.
//  - Untouched channels hold their value on every cycle.
// CONFIGURATION
//  SEQ_LOAD_EN defined:
//   - save_seq_n and seq_ptr exist. save_seq_n gets its own synchroniser and debouncer.
//   - A sequential commit writes channel seq_ptr exactly like a direct commit.
//   - seq_ptr then increments, wrapping CHANNELS-1 -> 0.
//   - A sequential and a direct commit to the same channel in one cycle make one write.
//     seq_ptr still advances.
//   - The sequential commit's channel takes part in the wr_ch highest-index rule.
//  SEQ_LOAD_EN undefined:
//   - Neither port exists, and no sequential logic is built.
//   - Behaviour is direct-save only.
// TESTING  (DATA_W=4, CHANNELS=2, DEBOUNCE_CYCLES=4)
//  1 Reset: hold reset 3 cycles -> q=0, loaded=00, all_loaded=0, wr_pulse=0.
//  2 Press: data_input=4'hA; save_n[0] low and held 20 cycles -> at edge 6, q[3:0]=A and
//    loaded=01; wr_pulse high for exactly 1 cycle with wr_ch=0; no further pulse while held.
//  3 Bounce: on save_n[1], low 2 cycles, high 1, low 3, high -> no write, loaded unchanged;
//    then low 10 cycles with data_input=4'h5 -> q[7:4]=5, all_loaded=1.
//  4 Simultaneous: data_input=4'h3; both save_n low on the same edge -> both channels =3,
//    a single 1-cycle wr_pulse, wr_ch=1.
//  5 Reset mid-debounce: save_n[0] low, reset asserted at edge 3 for 1 cycle, save_n[0]
//    still held -> no write before the count restarts; commit exactly 6 edges after reset
//    deasserts.
//  6 SEQ_LOAD_EN: three clean save_seq_n presses with data_input 1, 2, 3 -> q[3:0]=3,
//    q[7:4]=2, seq_ptr sequence 1, 0, 1; with the macro undefined, the build has no
//    save_seq_n port.

Source files
------------

// File: rtl/operand_latch_bank.sv
// operand_latch_bank: N-channel, W-bit operand register bank loaded from
// active-low pushbuttons. Each button is synchronised, debounced and
// press-edge detected, so one press makes exactly one write. The channel
// registers, the loaded flags and the write strobe/index are all registered.
// Optional feature: define SEQ_LOAD_EN to add the sequential save button
// (save_seq_n), which writes channel seq_ptr and then advances seq_ptr.
module operand_latch_bank #(
   parameter  int DATA_W          = 4,
   parameter  int CHANNELS        = 2,
   parameter  int DEBOUNCE_CYCLES = 16,
   localparam int CH_W            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [DATA_W-1:0]            data_input,
   input  logic [CHANNELS-1:0]          save_n,
`ifdef SEQ_LOAD_EN
   input  logic                         save_seq_n,
   output logic [CH_W-1:0]              seq_ptr,
`endif
   output logic [CHANNELS*DATA_W-1:0]   q,
   output logic [CHANNELS-1:0]          loaded,
   output logic                         all_loaded,
   output logic                         wr_pulse,
   output logic [CH_W-1:0]              wr_ch
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef SEQ_LOAD_EN
   localparam int NB = CHANNELS + 1;   // direct buttons, then the sequential button on top
`else
   localparam int NB = CHANNELS;
`endif

   logic [NB-1:0]             w_btn_n;
   logic [NB-1:0]             r_sync1;
   logic [NB-1:0]             r_sync2;
   logic [NB-1:0]             r_state;     // debounced level, 1 = released
   logic [NB-1:0]             r_state_d;   // debounced level one cycle earlier
   logic [CNT_W-1:0]          r_cnt [NB];
   logic [NB-1:0]             w_press;
   logic [CHANNELS-1:0]       w_wr_en;
   logic                      w_any_wr;
   logic [CH_W-1:0]           w_hi_ch;
   logic [CHANNELS*DATA_W-1:0] r_q;
   logic [CHANNELS-1:0]       r_loaded;
   logic                      r_wr_pulse;
   logic [CH_W-1:0]           r_wr_ch;

`ifdef SEQ_LOAD_EN
   logic [CH_W-1:0]           r_seq_ptr;
   assign w_btn_n = {save_seq_n, save_n};
   assign seq_ptr = r_seq_ptr;
`else
   assign w_btn_n = save_n;
`endif

   // Two-FF synchroniser and per-button debouncer; a partial count is discarded by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1   <= '1;
         r_sync2   <= '1;
         r_state   <= '1;
         r_state_d <= '1;
         for (int b = 0; b < NB; b++) begin
            r_cnt[b] <= '0;
         end
      end else begin
         r_sync1   <= w_btn_n;
         r_sync2   <= r_sync1;
         r_state_d <= r_state;
         for (int b = 0; b < NB; b++) begin
            if (r_sync2[b] == r_state[b]) begin
               r_cnt[b] <= '0;
            end else if (r_cnt[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               r_state[b] <= r_sync2[b];
               r_cnt[b]   <= '0;
            end else begin
               r_cnt[b] <= r_cnt[b] + 1'b1;
            end
         end
      end
   end

   // A press is a debounced 1->0 transition; releases never commit.
   assign w_press = r_state_d & ~r_state;

   // Merge direct and sequential commits into one write-enable set and pick the highest index.
   always_comb begin
      w_wr_en = w_press[CHANNELS-1:0];
      w_hi_ch = '0;
`ifdef SEQ_LOAD_EN
      if (w_press[CHANNELS]) begin
         w_wr_en[r_seq_ptr] = 1'b1;
      end else begin
         w_wr_en = w_wr_en;
      end
`endif
      for (int k = 0; k < CHANNELS; k++) begin
         if (w_wr_en[k]) begin
            w_hi_ch = CH_W'(k);
         end else begin
            w_hi_ch = w_hi_ch;
         end
      end
      w_any_wr = |w_wr_en;
   end

   // Channel registers, sticky loaded flags and the one-cycle-late write strobe/index.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q        <= '0;
         r_loaded   <= '0;
         r_wr_pulse <= 1'b0;
         r_wr_ch    <= '0;
      end else begin
         for (int k = 0; k < CHANNELS; k++) begin
            if (w_wr_en[k]) begin
               r_q[k*DATA_W +: DATA_W] <= data_input;
               r_loaded[k]             <= 1'b1;
            end
         end
         r_wr_pulse <= w_any_wr;
         if (w_any_wr) begin
            r_wr_ch <= w_hi_ch;
         end
      end
   end

`ifdef SEQ_LOAD_EN
   // Sequential pointer advances on every sequential commit, wrapping at the last channel.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_seq_ptr <= '0;
      end else if (w_press[CHANNELS]) begin
         if (r_seq_ptr == CH_W'(CHANNELS - 1)) begin
            r_seq_ptr <= '0;
         end else begin
            r_seq_ptr <= r_seq_ptr + 1'b1;
         end
      end
   end
`endif

   assign q          = r_q;
   assign loaded     = r_loaded;
   assign all_loaded = &r_loaded;
   assign wr_pulse   = r_wr_pulse;
   assign wr_ch      = r_wr_ch;

endmodule

// File: tb/tb_operand_latch_bank.sv
// Scoreboard bench for operand_latch_bank (DATA_W=4, CHANNELS=2, DEBOUNCE_CYCLES=4).
// Stimulus pushes the expected write (cycle, q, loaded, wr_ch, seq_ptr) into a
// queue; a monitor pops and compares on every cycle that wr_pulse is high.
module tb_operand_latch_bank;

   logic       clk;
   logic       reset;
   logic [3:0] data_input;
   logic [1:0] save_n;
   logic       save_seq_n;
   logic [0:0] seq_ptr;
   logic [7:0] q;
   logic [1:0] loaded;
   logic       all_loaded;
   logic       wr_pulse;
   logic [0:0] wr_ch;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      int         cyc;
      logic [7:0] q;
      logic [1:0] loaded;
      logic [0:0] ch;
      logic [0:0] ptr;
   } exp_t;

   exp_t sb[$];

   operand_latch_bank #(
      .DATA_W(4),
      .CHANNELS(2),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .data_input(data_input),
      .save_n(save_n),
`ifdef SEQ_LOAD_EN
      .save_seq_n(save_seq_n),
      .seq_ptr(seq_ptr),
`endif
      .q(q),
      .loaded(loaded),
      .all_loaded(all_loaded),
      .wr_pulse(wr_pulse),
      .wr_ch(wr_ch)
   );

`ifndef SEQ_LOAD_EN
   assign seq_ptr = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int c, input logic [7:0] eq, input logic [1:0] el,
                       input logic [0:0] ech, input logic [0:0] eptr);
      exp_t e;
      e.cyc = c; e.q = eq; e.loaded = el; e.ch = ech; e.ptr = eptr;
      sb.push_back(e);
   endtask

   // Monitor: every strobe must match the oldest expected write, at the expected cycle.
   always @(negedge clk) begin
      if (wr_pulse === 1'b1) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pulse: got wr_pulse=1 wr_ch=%0d expected no pulse (cycle %0d)",
                     wr_ch, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("pulse_cycle", cyc, e.cyc);
            chk("q", {24'd0, q}, {24'd0, e.q});
            chk("loaded", {30'd0, loaded}, {30'd0, e.loaded});
            chk("all_loaded", {31'd0, all_loaded}, {31'd0, &e.loaded});
            chk("wr_ch", {31'd0, wr_ch}, {31'd0, e.ch});
`ifdef SEQ_LOAD_EN
            chk("seq_ptr", {31'd0, seq_ptr}, {31'd0, e.ptr});
`endif
         end
      end
   end

   initial begin
      int e0;
      reset      = 1'b1;
      save_n     = 2'b11;
      save_seq_n = 1'b1;
      data_input = 4'h0;

      // 1: reset held three cycles
      wait_n(3);
      chk("reset_q", {24'd0, q}, 32'd0);
      chk("reset_loaded", {30'd0, loaded}, 32'd0);
      chk("reset_all_loaded", {31'd0, all_loaded}, 32'd0);
      chk("reset_wr_pulse", {31'd0, wr_pulse}, 32'd0);
      reset = 1'b0;
      wait_n(4);

      // 2: clean press on channel 0, held 20 cycles, single write
      data_input = 4'hA;
      save_n[0]  = 1'b0;
      e0 = cyc + 1;
      push(e0 + 6, 8'h0A, 2'b01, 1'b0, 1'b0);
      wait_n(5);
      chk("pre_commit_q", {24'd0, q}, 32'd0);
      wait_n(15);
      save_n[0] = 1'b1;
      wait_n(12);

      // 3: bounce on channel 1 must not write
      data_input = 4'hC;
      save_n[1] = 1'b0; wait_n(2);
      save_n[1] = 1'b1; wait_n(1);
      save_n[1] = 1'b0; wait_n(3);
      save_n[1] = 1'b1; wait_n(10);
      chk("bounce_loaded", {30'd0, loaded}, 32'd1);
      chk("bounce_q", {24'd0, q}, 32'h0A);
      data_input = 4'h5;
      save_n[1]  = 1'b0;
      e0 = cyc + 1;
      push(e0 + 6, 8'h5A, 2'b11, 1'b1, 1'b0);
      wait_n(10);
      save_n[1] = 1'b1;
      wait_n(12);

      // 4: simultaneous presses, one pulse, highest index reported
      data_input = 4'h3;
      save_n     = 2'b00;
      e0 = cyc + 1;
      push(e0 + 6, 8'h33, 2'b11, 1'b1, 1'b0);
      wait_n(10);
      save_n = 2'b11;
      wait_n(12);

      // 5: reset at edge e0+3 mid-debounce; count restarts from the next edge
      data_input = 4'h7;
      save_n[0]  = 1'b0;
      e0 = cyc + 1;
      wait_n(3);
      reset = 1'b1;
      wait_n(1);
      reset = 1'b0;
      chk("midreset_q", {24'd0, q}, 32'd0);
      chk("midreset_loaded", {30'd0, loaded}, 32'd0);
      push(e0 + 10, 8'h07, 2'b01, 1'b0, 1'b0);
      wait_n(14);
      save_n[0] = 1'b1;
      wait_n(12);

`ifdef SEQ_LOAD_EN
      // 6: three sequential presses, seq_ptr 1, 0, 1
      for (int i = 1; i <= 3; i++) begin
         data_input = 4'(i);
         save_seq_n = 1'b0;
         e0 = cyc + 1;
         if (i == 1)      push(e0 + 6, 8'h01, 2'b01, 1'b0, 1'b1);
         else if (i == 2) push(e0 + 6, 8'h21, 2'b11, 1'b1, 1'b0);
         else             push(e0 + 6, 8'h23, 2'b11, 1'b0, 1'b1);
         wait_n(10);
         save_seq_n = 1'b1;
         wait_n(12);
      end
`endif

      wait_n(5);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
